trap_sequencer: RTL and testbench

Multi-cycle controller that sits between the combinational trap-cause encoder and the CSR file / fetch unit. It accepts one trap (or MRET) at a time, stalls and drains the pipeline, then sequences the trap-entry CSR writes over the CSR file's single write port. It then redirects fetch and updates the current privilege level.

---
 rtl/trap_sequencer.sv | 151 +++++++++++++++
 tb/tb_trap_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// trap_sequencer: serialises trap entry / MRET over the single CSR write port.
// Flow: drain the pipeline, write mepc/mcause/mtval/mstatus (mstatus only for
// MRET), redirect fetch, update privilege.
// Optional feature: define TRAP_VECTORED_EN to honour mtvec vectored mode for
// interrupts; without it every trap targets the mtvec base (direct mode).
module trap_sequencer #(
    parameter int XLEN = 64
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            TRAP_REQ,
    input  logic [63:0]     TRAP_CAUSE,
    input  logic [XLEN-1:0] TRAP_PC,
    input  logic [XLEN-1:0] TRAP_TVAL,
    input  logic            MRET,
    input  logic            PIPE_DRAINED,
    input  logic [XLEN-1:0] MTVEC_IN,
    input  logic [XLEN-1:0] MEPC_IN,
    input  logic [XLEN-1:0] MSTATUS_IN,
    output logic            STALL,
    output logic            FLUSH,
    output logic            CSR_WE,
    output logic [11:0]     CSR_ADDR,
    output logic [XLEN-1:0] CSR_WDATA,
    output logic            PC_REDIRECT,
    output logic [XLEN-1:0] PC_TARGET,
    output logic [1:0]      PRIVILEGE,
    output logic            BUSY
);

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_EPC, S_CAUSE, S_TVAL, S_STATUS, S_REDIR
    } state_t;

    localparam logic [XLEN-1:0] LOW2_MASK = ~XLEN'(3);

    state_t          r_state, w_next;
    logic            r_ret;
    logic [63:0]     r_cause;
    logic [XLEN-1:0] r_pc, r_tval;
    logic [1:0]      r_priv_cap;   // privilege at the moment the trap was taken
    logic [1:0]      r_ret_priv;   // MPP sampled when mstatus is rewritten on MRET
    logic [1:0]      r_priv;
    logic [XLEN-1:0] r_status_wdata;
    logic [XLEN-1:0] r_pc_target;
    logic [XLEN-1:0] w_status;
    logic [XLEN-1:0] w_target;

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (TRAP_REQ || MRET) w_next = S_DRAIN;
            S_DRAIN:  if (PIPE_DRAINED) w_next = r_ret ? S_STATUS : S_EPC;
            S_EPC:    w_next = S_CAUSE;
            S_CAUSE:  w_next = S_TVAL;
            S_TVAL:   w_next = S_STATUS;
            S_STATUS: w_next = S_REDIR;
            S_REDIR:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // New mstatus value: trap entry stacks MIE into MPIE, MRET unstacks it
    always_comb begin
        w_status = MSTATUS_IN;
        if (r_ret) begin
            w_status[3]     = MSTATUS_IN[7];
            w_status[7]     = 1'b1;
            w_status[12:11] = 2'b00;
        end else begin
            w_status[7]     = MSTATUS_IN[3];
            w_status[3]     = 1'b0;
            w_status[12:11] = r_priv_cap;
        end
    end

    // Redirect target: mepc for MRET, mtvec base (optionally vectored) for traps
    always_comb begin
        w_target = MTVEC_IN & LOW2_MASK;
        if (r_ret) begin
            w_target = MEPC_IN & LOW2_MASK;
        end
`ifdef TRAP_VECTORED_EN
        else if (MTVEC_IN[1:0] == 2'b01 && r_cause[63]) begin
            w_target = (MTVEC_IN & LOW2_MASK) + XLEN'({r_cause[5:0], 2'b00});
        end
`endif
    end

    // Capture request context and pre-register values that depend on live CSR
    // inputs, so no input reaches an output combinationally
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ret          <= 1'b0;
            r_cause        <= '0;
            r_pc           <= '0;
            r_tval         <= '0;
            r_priv_cap     <= '0;
            r_ret_priv     <= '0;
            r_priv         <= 2'd3;
            r_status_wdata <= '0;
            r_pc_target    <= '0;
        end else begin
            if (r_state == S_IDLE && TRAP_REQ) begin
                r_ret      <= 1'b0;
                r_cause    <= TRAP_CAUSE;
                r_pc       <= TRAP_PC;
                r_tval     <= TRAP_TVAL;
                r_priv_cap <= r_priv;
            end else if (r_state == S_IDLE && MRET) begin
                r_ret <= 1'b1;
            end
            if (w_next == S_STATUS && r_state != S_STATUS) begin
                r_status_wdata <= w_status;
                r_ret_priv     <= MSTATUS_IN[12:11];
            end
            if (w_next == S_REDIR) begin
                r_pc_target <= w_target;
                r_priv      <= r_ret ? r_ret_priv : 2'd3;
            end
        end
    end

    // Output decode from the state register and registered context only
    always_comb begin
        STALL       = (r_state != S_IDLE);
        BUSY        = (r_state != S_IDLE);
        FLUSH       = (r_state == S_DRAIN);
        PC_REDIRECT = (r_state == S_REDIR);
        PC_TARGET   = r_pc_target;
        PRIVILEGE   = r_priv;
        CSR_WE      = 1'b0;
        CSR_ADDR    = 12'h000;
        CSR_WDATA   = '0;
        case (r_state)
            S_EPC:    begin CSR_WE = 1'b1; CSR_ADDR = 12'h341; CSR_WDATA = r_pc & LOW2_MASK; end
            S_CAUSE:  begin CSR_WE = 1'b1; CSR_ADDR = 12'h342; CSR_WDATA = XLEN'(r_cause); end
            S_TVAL:   begin CSR_WE = 1'b1; CSR_ADDR = 12'h343; CSR_WDATA = r_tval; end
            S_STATUS: begin CSR_WE = 1'b1; CSR_ADDR = 12'h300; CSR_WDATA = r_status_wdata; end
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: the driver pushes expected CSR writes
// and redirect targets; a negedge monitor pops and compares them.
module tb_trap_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        TRAP_REQ, MRET, PIPE_DRAINED;
    logic [63:0] TRAP_CAUSE, TRAP_PC, TRAP_TVAL, MTVEC_IN, MEPC_IN, MSTATUS_IN;
    logic        STALL, FLUSH, CSR_WE, PC_REDIRECT, BUSY;
    logic [11:0] CSR_ADDR;
    logic [63:0] CSR_WDATA, PC_TARGET;
    logic [1:0]  PRIVILEGE;

    trap_sequencer #(.XLEN(64)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .TRAP_REQ(TRAP_REQ), .TRAP_CAUSE(TRAP_CAUSE),
        .TRAP_PC(TRAP_PC), .TRAP_TVAL(TRAP_TVAL), .MRET(MRET), .PIPE_DRAINED(PIPE_DRAINED),
        .MTVEC_IN(MTVEC_IN), .MEPC_IN(MEPC_IN), .MSTATUS_IN(MSTATUS_IN),
        .STALL(STALL), .FLUSH(FLUSH), .CSR_WE(CSR_WE), .CSR_ADDR(CSR_ADDR),
        .CSR_WDATA(CSR_WDATA), .PC_REDIRECT(PC_REDIRECT), .PC_TARGET(PC_TARGET),
        .PRIVILEGE(PRIVILEGE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [11:0] a; logic [63:0] d; } wr_t;
    wr_t         exp_wr[$];
    logic [63:0] exp_tgt[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  model_priv = 2'd3;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: every presented CSR write / redirect must match the next expectation
    always @(negedge CLK) begin
        if (RESET_N === 1'b1) begin
            if (CSR_WE) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_csr_write actual=%h/%h expected=none", CSR_ADDR, CSR_WDATA);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("csr_addr", 64'(CSR_ADDR), 64'(e.a));
                    chk("csr_wdata", CSR_WDATA, e.d);
                end
            end else begin
                chk("csr_addr_idle", 64'(CSR_ADDR), 64'h0);
                chk("csr_wdata_idle", CSR_WDATA, 64'h0);
            end
            if (PC_REDIRECT) begin
                if (exp_tgt.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_redirect actual=%h expected=none", PC_TARGET);
                end else begin
                    chk("pc_target", PC_TARGET, exp_tgt.pop_front());
                end
            end
        end
    end

    // Reference model: expected trap / MRET effects from the architectural rules
    function automatic logic [63:0] trap_target(input logic [63:0] mtvec, input logic [63:0] cause);
        logic [63:0] base;
        base = mtvec & ~64'd3;
`ifdef TRAP_VECTORED_EN
        if (mtvec[1:0] == 2'd1 && cause[63]) return base + 64'(cause[5:0]) * 4;
`endif
        return base + 64'd0 * cause;
    endfunction

    // One full sequence; d = cycles PIPE_DRAINED stays low; dual = MRET together
    // with the trap; intrude = extra trap+MRET while busy
    task automatic do_seq(input bit is_ret, input logic [63:0] cause, input logic [63:0] pc,
                          input logic [63:0] tval, input logic [63:0] mtvec,
                          input logic [63:0] mepc, input logic [63:0] mstatus,
                          input int d, input bit dual, input bit intrude, input int stop_at);
        int busy = 0, fl = 0, wr = 0, bad = 0;
        logic [63:0] st;
        TRAP_CAUSE = cause; TRAP_PC = pc; TRAP_TVAL = tval;
        MTVEC_IN = mtvec; MEPC_IN = mepc; MSTATUS_IN = mstatus;
        PIPE_DRAINED = 1'b0;
        TRAP_REQ = !is_ret;
        MRET = is_ret | dual;
        if (!is_ret) begin
            st = (mstatus & ~64'h1888) | (64'(mstatus[3]) << 7) | (64'(model_priv) << 11);
            exp_wr.push_back('{12'h341, pc & ~64'd3});
            exp_wr.push_back('{12'h342, cause});
            exp_wr.push_back('{12'h343, tval});
            exp_wr.push_back('{12'h300, st});
            exp_tgt.push_back(trap_target(mtvec, cause));
        end else begin
            st = (mstatus & ~64'h1888) | 64'h80 | (64'(mstatus[7]) << 3);
            exp_wr.push_back('{12'h300, st});
            exp_tgt.push_back(mepc & ~64'd3);
        end
        for (int k = 1; k <= 60; k++) begin
            @(posedge CLK); #1;
            TRAP_REQ = 1'b0; MRET = 1'b0;
            if (intrude && k == 3) begin
                TRAP_REQ = 1'b1; MRET = 1'b1; TRAP_CAUSE = 64'h77; TRAP_PC = 64'h9990;
            end
            if (k == stop_at) begin
                RESET_N = 1'b0; #1;
                chk("rst_busy", 64'(BUSY), 64'd0);
                chk("rst_csr_we", 64'(CSR_WE), 64'd0);
                chk("rst_priv", 64'(PRIVILEGE), 64'd3);
                chk("rst_target", PC_TARGET, 64'd0);
                exp_wr.delete(); exp_tgt.delete();
                model_priv = 2'd3;
                #10 RESET_N = 1'b1;
                return;
            end
            PIPE_DRAINED = (k > d);
            if (k == 1) chk("stall_on_accept", 64'(STALL), 64'd1);
            if (BUSY) busy++;
            if (FLUSH) fl++;
            if (CSR_WE) wr++;
            if (FLUSH && CSR_WE) bad++;
            if (!BUSY) break;
        end
        TRAP_CAUSE = cause; TRAP_PC = pc;
        if (!is_ret) model_priv = 2'd3;
        else         model_priv = mstatus[12:11];
        chk("busy_cycles", 64'(busy), is_ret ? 64'(3 + d) : 64'(6 + d));
        chk("flush_cycles", 64'(fl), 64'(1 + d));
        chk("csr_write_count", 64'(wr), is_ret ? 64'd1 : 64'd4);
        chk("write_during_drain", 64'(bad), 64'd0);
        chk("pending_writes", 64'(exp_wr.size()), 64'd0);
        chk("pending_redirects", 64'(exp_tgt.size()), 64'd0);
        chk("privilege", 64'(PRIVILEGE), 64'(model_priv));
    endtask

    initial begin
        RESET_N = 1'b0; TRAP_REQ = 1'b0; MRET = 1'b0; PIPE_DRAINED = 1'b0;
        TRAP_CAUSE = '0; TRAP_PC = '0; TRAP_TVAL = '0;
        MTVEC_IN = '0; MEPC_IN = '0; MSTATUS_IN = '0;
        #12;
        chk("reset_stall", 64'(STALL), 64'd0);
        chk("reset_flush", 64'(FLUSH), 64'd0);
        chk("reset_csr_we", 64'(CSR_WE), 64'd0);
        chk("reset_csr_addr", 64'(CSR_ADDR), 64'd0);
        chk("reset_csr_wdata", CSR_WDATA, 64'd0);
        chk("reset_redirect", 64'(PC_REDIRECT), 64'd0);
        chk("reset_target", PC_TARGET, 64'd0);
        chk("reset_busy", 64'(BUSY), 64'd0);
        chk("reset_priv", 64'(PRIVILEGE), 64'd3);
        RESET_N = 1'b1;
        @(posedge CLK); #1;

        // Load fault, pipeline already drained
        do_seq(0, 64'd5, 64'h1006, 64'hDEAD, 64'h8000, 64'h0, 64'h8, 0, 0, 0, 0);
        // Same trap with a 3-cycle drain hold
        do_seq(0, 64'd5, 64'h1006, 64'hDEAD, 64'h8000, 64'h0, 64'h8, 3, 0, 0, 0);
        // MRET back to U-mode
        do_seq(1, 64'd0, 64'h0, 64'h0, 64'h8000, 64'h2000, 64'h80, 0, 0, 0, 0);
        // Simultaneous trap+MRET, then a trap while busy (taken from U-mode)
        do_seq(0, 64'd2, 64'h3000, 64'h0, 64'h8000, 64'h0, 64'h88, 1, 1, 1, 0);
        // Interrupt with vectored mtvec
        do_seq(0, 64'h8000_0000_0000_0007, 64'h4000, 64'h0, 64'h8001, 64'h0, 64'h0, 0, 0, 0, 0);
        // Drop back to U-mode, then reset during W_CAUSE
        do_seq(1, 64'd0, 64'h0, 64'h0, 64'h0, 64'h5000, 64'h0, 0, 0, 0, 0);
        do_seq(0, 64'd3, 64'h6000, 64'h1, 64'h8000, 64'h0, 64'h8, 0, 0, 0, 3);
        repeat (6) @(posedge CLK);
        #1;
        chk("post_reset_priv", 64'(PRIVILEGE), 64'd3);
        chk("post_reset_busy", 64'(BUSY), 64'd0);

        // Randomised traps and returns
        for (int i = 0; i < 30; i++) begin
            logic [63:0] c;
            c = {1'($urandom_range(0, 1)), 55'd0, 8'($urandom_range(0, 255))};
            do_seq($urandom_range(0, 3) == 0, c, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), 0);
        end

        repeat (2) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
